// File: rtl/fetch_unit_pkg.sv
// Shared constants, FSM encoding and buffer entry type for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int XLEN       = 32;
    localparam int INST_BYTES = 4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_WAIT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction memory request/response, execute redirect and decode handshake.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic [XLEN-1:0] fetch_addr;
    logic            fetch_req;
    logic [XLEN-1:0] request_data;
    logic            fetch_data_valid;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_inst;
    logic [XLEN-1:0] dec_pc;

    modport master (
        output fetch_addr, fetch_req, dec_valid, dec_inst, dec_pc,
        input  request_data, fetch_data_valid, redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
        input  fetch_addr, fetch_req, dec_valid, dec_inst, dec_pc,
        output request_data, fetch_data_valid, redirect_valid, redirect_pc, dec_ready
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// In-order instruction buffer: DEPTH entries of {pc, inst} with push, pop and flush.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     din,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Flush wins over any push/pop presented in the same cycle.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = din;
                tail_d        = next_ptr(tail_q);
            end
            if (pop) begin
                head_d = next_ptr(head_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[head_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, fetch FSM, memory request and decode-side buffer handshake.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             push;
    logic             pop;
    logic             buf_room;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head_entry;
    fetch_entry_t     push_entry;

    // A pop in the same cycle frees a slot, so a full buffer can still accept a fetch.
    assign bus.dec_valid  = (count != '0) && !bus.redirect_valid;
    assign pop            = bus.dec_valid && bus.dec_ready;
    assign buf_room       = (count < CNT_W'(DEPTH)) || pop;
    assign bus.fetch_req  = ((state_q == FS_RUN) || (state_q == FS_WAIT))
                            && !bus.redirect_valid && buf_room;
    assign push           = bus.fetch_req && bus.fetch_data_valid;
    assign bus.fetch_addr = word_align(pc_q);
    assign bus.dec_inst   = head_entry.inst;
    assign bus.dec_pc     = head_entry.pc;
    assign push_entry     = '{pc: word_align(pc_q), inst: bus.request_data};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            FS_BOOT: state_d = FS_RUN;
            FS_RUN:  if (bus.fetch_req && !bus.fetch_data_valid) state_d = FS_WAIT;
            FS_WAIT: if (push) state_d = FS_RUN;
            default: state_d = FS_BOOT;
        endcase
        if (push) begin
            pc_d = pc_q + XLEN'(INST_BYTES);
        end
        if (bus.redirect_valid) begin
            pc_d = word_align(bus.redirect_pc);
            if (state_q != FS_BOOT) state_d = FS_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FS_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   (push_entry),
        .head  (head_entry),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected {pc, inst} queued on fetch, compared on decode pop.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2.master)
    );

    int           n_tests = 0;
    int           n_fail  = 0;
    fetch_entry_t sb[$];
    logic [31:0]  m_pc;
    logic         m_run;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic set_idle();
        bus.dec_ready        = 1'b0;
        bus.fetch_data_valid = 1'b0;
        bus.redirect_valid   = 1'b0;
        bus.redirect_pc      = 32'h0;
        bus.request_data     = 32'h0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        sb.delete();
        m_pc  = 32'h0;
        m_run = 1'b0;
    endtask

    // One clock of stimulus; entered and left at posedge+1.
    task automatic tick(input logic rdy, input logic fdv, input logic redir, input logic [31:0] rpc);
        logic         exp_dv;
        logic         exp_pop;
        logic         exp_req;
        fetch_entry_t e;
        bus.dec_ready        = rdy;
        bus.fetch_data_valid = fdv;
        bus.redirect_valid   = redir;
        bus.redirect_pc      = rpc;
        bus.request_data     = mem_word(bus.fetch_addr);
        #1;
        exp_dv  = (sb.size() != 0) && !redir;
        exp_pop = exp_dv && rdy;
        exp_req = m_run && !redir && ((sb.size() < DEPTH) || exp_pop);
        n_tests++;
        if (bus.fetch_req !== exp_req) begin
            n_fail++;
            $display("FAIL fetch_req t=%0t got %b expected %b", $time, bus.fetch_req, exp_req);
        end
        n_tests++;
        if (bus.dec_valid !== exp_dv) begin
            n_fail++;
            $display("FAIL dec_valid t=%0t got %b expected %b", $time, bus.dec_valid, exp_dv);
        end
        n_tests++;
        if (bus.fetch_addr !== m_pc) begin
            n_fail++;
            $display("FAIL fetch_addr t=%0t got %h expected %h", $time, bus.fetch_addr, m_pc);
        end
        if (exp_pop) begin
            e = sb.pop_front();
            n_tests++;
            if (bus.dec_pc !== e.pc || bus.dec_inst !== e.inst) begin
                n_fail++;
                $display("FAIL dec_head t=%0t got pc=%h inst=%h expected pc=%h inst=%h",
                         $time, bus.dec_pc, bus.dec_inst, e.pc, e.inst);
            end
        end
        if (exp_req && fdv) begin
            sb.push_back('{pc: m_pc, inst: mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
        end
        if (redir) begin
            sb.delete();
            m_pc = {rpc[31:2], 2'b00};
        end
        m_run = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (bus.fetch_req !== 1'b0 || bus.dec_valid !== 1'b0 || bus.fetch_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs req=%b dv=%b addr=%h expected 0 0 00000000",
                     bus.fetch_req, bus.dec_valid, bus.fetch_addr);
        end
        rst   = 1'b0;
        sb.delete();
        m_pc  = 32'h0;
        m_run = 1'b0;
    endtask

    task automatic test_sequential();
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        n_tests++;
        if (bus.dec_valid !== 1'b0 || bus.fetch_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL seq_cycle1 dv=%b addr=%h expected 0 00000000", bus.dec_valid, bus.fetch_addr);
        end
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        n_tests++;
        if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h0 || bus.fetch_addr !== 32'h4) begin
            n_fail++;
            $display("FAIL seq_cycle2 dv=%b pc=%h addr=%h expected 1 00000000 00000004",
                     bus.dec_valid, bus.dec_pc, bus.fetch_addr);
        end
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 32'h0);
        n_tests++;
        if (bus.fetch_req !== 1'b0 || bus.fetch_addr !== 32'h8 || bus.dec_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL bp_full req=%b addr=%h pc=%h expected 0 00000008 00000000",
                     bus.fetch_req, bus.fetch_addr, bus.dec_pc);
        end
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        n_tests++;
        if (bus.fetch_addr !== 32'hC) begin
            n_fail++;
            $display("FAIL bp_resume addr=%h expected 0000000c", bus.fetch_addr);
        end
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        bus.dec_ready = 1'b0;
        #1;
        n_tests++;
        if (bus.fetch_req !== 1'b0 || bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h4) begin
            n_fail++;
            $display("FAIL full_swap req=%b dv=%b pc=%h expected 0 1 00000004",
                     bus.fetch_req, bus.dec_valid, bus.dec_pc);
        end
        for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        bus.redirect_valid = 1'b0;
        #1;
        n_tests++;
        if (bus.fetch_addr !== 32'h100 || bus.dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_addr addr=%h dv=%b expected 00000100 0", bus.fetch_addr, bus.dec_valid);
        end
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        n_tests++;
        if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h100) begin
            n_fail++;
            $display("FAIL redirect_target dv=%b pc=%h expected 1 00000100", bus.dec_valid, bus.dec_pc);
        end
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_wait();
        logic [31:0] held;
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
        held = m_pc;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if (dut.state_q !== FS_WAIT || bus.fetch_addr !== held || bus.fetch_req !== 1'b1
            || bus.dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_hold state=%0d addr=%h req=%b dv=%b expected 2 %h 1 0",
                     dut.state_q, bus.fetch_addr, bus.fetch_req, bus.dec_valid, held);
        end
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_pc_wrap();
        logic [31:0] exp_addr [5];
        exp_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        bus2.dec_ready        = 1'b1;
        bus2.fetch_data_valid = 1'b1;
        bus2.redirect_valid   = 1'b0;
        bus2.redirect_pc      = 32'h0;
        bus2.request_data     = 32'h0;
        rst2 = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus2.request_data = mem_word(bus2.fetch_addr);
            #1;
            n_tests++;
            if (bus2.fetch_addr !== exp_addr[i] || bus2.fetch_req !== (i != 0)) begin
                n_fail++;
                $display("FAIL wrap_fetch%0d addr=%h req=%b expected %h %b",
                         i, bus2.fetch_addr, bus2.fetch_req, exp_addr[i], (i != 0));
            end
            if (i >= 2) begin
                n_tests++;
                if (bus2.dec_valid !== 1'b1 || bus2.dec_pc !== exp_addr[i-1]
                    || bus2.dec_inst !== mem_word(exp_addr[i-1])) begin
                    n_fail++;
                    $display("FAIL wrap_dec%0d dv=%b pc=%h inst=%h expected 1 %h %h", i,
                             bus2.dec_valid, bus2.dec_pc, bus2.dec_inst,
                             exp_addr[i-1], mem_word(exp_addr[i-1]));
                end
            end
            @(posedge clk); #1;
        end
        rst2 = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (bus2.dec_valid !== 1'b0 || bus2.fetch_req !== 1'b0 || bus2.fetch_addr !== 32'hFFFF_FFF8) begin
            n_fail++;
            $display("FAIL wrap_midreset dv=%b req=%b addr=%h expected 0 0 fffffff8",
                     bus2.dec_valid, bus2.fetch_req, bus2.fetch_addr);
        end
        rst2 = 1'b0;
    endtask

    initial begin
        set_idle();
        m_pc  = 32'h0;
        m_run = 1'b0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_full_push_pop();
        test_redirect();
        test_wait();
        test_reset();
        test_pc_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
